prio_enable_reg_bank: RTL and testbench

Parametrised multi-port enable register: CHANNELS independent write ports, each with its own enable and data, update one WIDTH-bit holding register. It replaces hand-written banks of parallel enable-gated always blocks that drive the same register with no defined winner. The block arbitrates simultaneous enables deterministically, reports the winning port, and counts write conflicts for debug. It sits in the register/test-case layer wherever several control sources load a shared data register.

---
 rtl/prio_enable_reg_bank.sv | 92 +++++++++
 tb/tb_prio_enable_reg_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enable_reg_bank.sv
// Multi-port enable register: CHANNELS write ports share one WIDTH-bit register,
// with deterministic arbitration (fixed priority or round-robin) and conflict counting.
module prio_enable_reg_bank #(
  parameter int                 WIDTH     = 4,
  parameter int                 CHANNELS  = 8,
  parameter int                 CNT_W     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 RR_MODE   = 0,
  localparam int                IDX_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d_in,
  input  logic                      clr_cnt,
  output logic [WIDTH-1:0]          d_out,
  output logic [IDX_W-1:0]          wr_idx,
  output logic                      valid,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  logic             any_en;
  logic             multi_en;
  int               cand;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (en[i] && !found) begin
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end else begin
      // Scan starting at ptr; ptr < CHANNELS, so one subtraction wraps correctly.
      for (int k = 0; k < CHANNELS; k++) begin
        cand = int'(ptr) + k;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        cand_idx = IDX_W'(cand);
        if (en[cand_idx] && !found) begin
          grant_idx = cand_idx;
          found     = 1'b1;
        end
      end
    end
  end

  // Wrap at CHANNELS, not 2**IDX_W, so non-power-of-2 banks never point past the last port.
  assign ptr_next = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + IDX_W'(1);
  assign any_en   = |en;
  // At least two bits set iff clearing the lowest set bit leaves something behind.
  assign multi_en = |(en & (en - CHANNELS'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out        <= RESET_VAL;
      wr_idx       <= '0;
      valid        <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      ptr          <= '0;
    end else begin
      if (any_en) begin
        d_out  <= d_in[grant_idx*WIDTH +: WIDTH];
        wr_idx <= grant_idx;
        valid  <= 1'b1;
        if (RR_MODE != 0) ptr <= ptr_next;
      end
      conflict <= multi_en;
      if (clr_cnt) begin
        conflict_cnt <= '0;
      end else if (multi_en && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prio_enable_reg_bank.sv
// Scoreboard bench for prio_enable_reg_bank: three configurations (fixed priority,
// 8-port round-robin, 5-port round-robin with 2-bit counter) against a behavioural model.
module tb_prio_enable_reg_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  en0, en1;
  logic [4:0]  en2;
  logic [31:0] din0, din1;
  logic [19:0] din2;
  logic        clr0, clr1, clr2;
  logic [3:0]  d0, d1, d2;
  logic [2:0]  w0, w1, w2;
  logic        v0, v1, v2, c0, c1, c2;
  logic [7:0]  n0, n1;
  logic [1:0]  n2;

  prio_enable_reg_bank #(.WIDTH(4), .CHANNELS(8), .CNT_W(8), .RESET_VAL(4'h0), .RR_MODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en0), .d_in(din0), .clr_cnt(clr0),
    .d_out(d0), .wr_idx(w0), .valid(v0), .conflict(c0), .conflict_cnt(n0));

  prio_enable_reg_bank #(.WIDTH(4), .CHANNELS(8), .CNT_W(8), .RESET_VAL(4'h0), .RR_MODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .d_in(din1), .clr_cnt(clr1),
    .d_out(d1), .wr_idx(w1), .valid(v1), .conflict(c1), .conflict_cnt(n1));

  prio_enable_reg_bank #(.WIDTH(4), .CHANNELS(5), .CNT_W(2), .RESET_VAL(4'hA), .RR_MODE(1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .d_in(din2), .clr_cnt(clr2),
    .d_out(d2), .wr_idx(w2), .valid(v2), .conflict(c2), .conflict_cnt(n2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int inst;
    int d;
    int w;
    int v;
    int c;
    int n;
  } exp_t;
  exp_t sb[$];

  int NCH[3]  = '{8, 8, 5};
  int RR[3]   = '{0, 1, 1};
  int CMAX[3] = '{255, 255, 3};
  int RV[3]   = '{0, 0, 10};

  int m_d[3], m_w[3], m_v[3], m_c[3], m_n[3], m_p[3];
  logic [31:0] s_en[3], s_din[3];
  bit          s_clr[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_d[k] = RV[k]; m_w[k] = 0; m_v[k] = 0; m_c[k] = 0; m_n[k] = 0; m_p[k] = 0;
    end
  endfunction

  function automatic void model_step(input int k);
    logic [31:0] e;
    int g;
    int n;
    n = NCH[k];
    e = s_en[k] & ((32'd1 << n) - 32'd1);
    g = -1;
    for (int off = 0; off < n; off++) begin
      int j;
      j = (RR[k] != 0) ? (m_p[k] + off) % n : off;
      if (e[j] && g < 0) g = j;
    end
    if (g >= 0) begin
      m_d[k] = int'((s_din[k] >> (4 * g)) & 32'hF);
      m_w[k] = g;
      m_v[k] = 1;
      if (RR[k] != 0) m_p[k] = (g + 1) % n;
    end
    m_c[k] = ($countones(e) >= 2) ? 1 : 0;
    if (s_clr[k]) m_n[k] = 0;
    else if (m_c[k] == 1 && m_n[k] < CMAX[k]) m_n[k] = m_n[k] + 1;
  endfunction

  task automatic push_exp();
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.inst = k; e.d = m_d[k]; e.w = m_w[k]; e.v = m_v[k]; e.c = m_c[k]; e.n = m_n[k];
      sb.push_back(e);
    end
  endtask

  task automatic pop_cmp(input string ph);
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] ad, aw, av, ac, an;
      e = sb.pop_front();
      case (e.inst)
        0:       begin ad = 32'(d0); aw = 32'(w0); av = 32'(v0); ac = 32'(c0); an = 32'(n0); end
        1:       begin ad = 32'(d1); aw = 32'(w1); av = 32'(v1); ac = 32'(c1); an = 32'(n1); end
        default: begin ad = 32'(d2); aw = 32'(w2); av = 32'(v2); ac = 32'(c2); an = 32'(n2); end
      endcase
      check($sformatf("%s.i%0d.d_out", ph, e.inst), ad, e.d);
      check($sformatf("%s.i%0d.wr_idx", ph, e.inst), aw, e.w);
      check($sformatf("%s.i%0d.valid", ph, e.inst), av, e.v);
      check($sformatf("%s.i%0d.conflict", ph, e.inst), ac, e.c);
      check($sformatf("%s.i%0d.conflict_cnt", ph, e.inst), an, e.n);
    end
  endtask

  task automatic apply_inputs();
    en0 = s_en[0][7:0]; din0 = s_din[0];        clr0 = s_clr[0];
    en1 = s_en[1][7:0]; din1 = s_din[1];        clr1 = s_clr[1];
    en2 = s_en[2][4:0]; din2 = s_din[2][19:0];  clr2 = s_clr[2];
  endtask

  // One clock: drive, predict, then compare 1 time unit after the edge.
  task automatic tick(input string ph);
    apply_inputs();
    for (int k = 0; k < 3; k++) model_step(k);
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp(ph);
    check({ph, ".i2.ptr_range"}, 32'(u2.ptr < 3'd5), 1);
    for (int k = 0; k < 3; k++) begin
      s_en[k]  = '0;
      s_clr[k] = 1'b0;
    end
  endtask

  int sat_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_en[k] = '0; s_din[k] = '0; s_clr[k] = 1'b0;
    end
    apply_inputs();
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp();
    pop_cmp("reset");

    // Fixed priority: ports 2, 5, 7 requested together, lowest wins.
    s_din[0] = 32'hC090_0300;
    s_en[0]  = 8'hA4;
    tick("fp1");
    check("fp1.d_out", 32'(d0), 4'h3);
    check("fp1.wr_idx", 32'(w0), 2);
    check("fp1.conflict", 32'(c0), 1);
    check("fp1.cnt", 32'(n0), 1);
    s_en[0] = 8'h80;
    tick("fp2");
    check("fp2.d_out", 32'(d0), 4'hC);
    check("fp2.wr_idx", 32'(w0), 7);
    check("fp2.conflict", 32'(c0), 0);

    // Round-robin rotation with all ports requesting.
    s_din[1] = 32'h7654_3210;
    for (int i = 0; i < 9; i++) begin
      s_en[1] = 8'hFF;
      tick("rr_rot");
      check("rr_rot.wr_idx", 32'(w1), i % 8);
    end
    check("rr_rot.cnt", 32'(n1), 9);

    // Skip and wrap: grant 6 leaves ptr at 7, then 7 and 0 are skipped.
    s_en[1] = 8'h40;
    tick("rr_g6");
    check("rr_g6.wr_idx", 32'(w1), 6);
    s_en[1] = 8'h06;
    tick("rr_wrap");
    check("rr_wrap.wr_idx", 32'(w1), 1);
    s_en[1] = 8'h06;
    tick("rr_next");
    check("rr_next.wr_idx", 32'(w1), 2);

    // Five-port round-robin, 2-bit saturating counter.
    s_din[2] = 32'h0004_3215;
    for (int i = 0; i < 5; i++) begin
      s_en[2] = 32'h11;
      tick("np2");
      check("np2.wr_idx", 32'(w2), (i % 2 == 0) ? 0 : 4);
      check("np2.cnt", 32'(n2), sat_seq[i]);
    end
    s_en[2] = 32'h10;
    tick("np2_single");
    check("np2_single.cnt", 32'(n2), 3);
    check("np2_single.conflict", 32'(c2), 0);
    s_en[2]  = 32'h03;
    s_clr[2] = 1'b1;
    tick("clr");
    check("clr.cnt", 32'(n2), 0);
    check("clr.conflict", 32'(c2), 1);
    check("clr.d_out", 32'(d2), 4'h5);

    // Asynchronous reset in the middle of a busy stream.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        s_en[k]  = 32'hFF;
        s_din[k] = $urandom;
      end
      tick("busy");
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    pop_cmp("rst_async");
    check("rst_async.valid0", 32'(v0), 0);
    apply_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) tick("idle");
    check("idle.d_out2", 32'(d2), 4'hA);

    // Random traffic on all three banks.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        s_en[k]  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(0, 255));
        s_din[k] = $urandom;
        s_clr[k] = ($urandom_range(0, 15) == 0);
      end
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
